// File: rtl/ps2_pkg.sv
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared Set-2 byte constants, decoder states and the key-event record.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

   localparam logic [7:0] PS2_E0     = 8'hE0;
   localparam logic [7:0] PS2_E1     = 8'hE1;
   localparam logic [7:0] PS2_F0     = 8'hF0;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERRF   = 8'hFF;

   localparam logic [7:0] PS2_LSHIFT  = 8'h12;
   localparam logic [7:0] PS2_RSHIFT  = 8'h59;
   localparam logic [7:0] PS2_CAPS    = 8'h58;
   localparam logic [2:0] PS2_E1_TAIL = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_E0   = 3'd1,
      ST_F0   = 3'd2,
      ST_E0F0 = 3'd3,
      ST_SKIP = 3'd4
   } ps2_state_t;

   typedef struct packed {
      logic [7:0] scan_code;
      logic       extended;
      logic       shift_mode;
      logic       released;
   } ps2_event_t;

   // Keyboard-to-host status bytes that never carry a key code.
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == PS2_BAT_OK) || (b == PS2_ACK)  || (b == PS2_RESEND) ||
             (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERRF);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_event_slot.sv
// ============================================================================
// Module : ps2_event_slot
// Brief  : One-entry valid/ready holding register; flags events dropped when full.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_event_slot
   import ps2_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  ps2_event_t load_evt,
   input  logic       key_ready,
   output logic       key_valid,
   output ps2_event_t held_evt,
   output logic       overflow
);

   logic       r_valid;
   ps2_event_t r_evt;
   logic       r_overflow;
   logic       w_accept;

   // A transfer in the same cycle frees the slot, so the new event loads without a bubble.
   assign w_accept = load && (!r_valid || key_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_evt      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= load && r_valid && !key_ready;
         if (w_accept) begin
            r_valid <= 1'b1;
            r_evt   <= load_evt;
         end else if (key_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign key_valid = r_valid;
   assign held_evt  = r_evt;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
// ============================================================================
// Module : ps2_scan_decoder
// Brief  : Strips E0/F0 prefixes from Set-2 bytes, tracks shift, skips Pause.
//          Optional caps-lock tracking: PS2_SCAN_DECODER_CAPS_LOCK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter bit EMIT_BREAK     = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_error,
   input  logic       key_ready,
   output logic       key_valid,
   output logic [7:0] scan_code,
   output logic       extended,
   output logic       shift_mode,
   output logic       released,
   output logic       overflow
`ifdef PS2_SCAN_DECODER_CAPS_LOCK_EN
   ,
   output logic       caps_lock
`endif
);

   localparam int                 c_TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

   ps2_state_t         r_state;
   ps2_state_t         w_state_nxt;
   logic [2:0]         r_skip_cnt;
   logic [2:0]         w_skip_nxt;
   logic [c_TMO_W-1:0] r_tmo_cnt;
   logic               r_lshift;
   logic               r_rshift;
   logic               w_lshift_nxt;
   logic               w_rshift_nxt;
   logic               w_timeout;
   logic               w_proc;
   logic               w_proc_ext;
   logic               w_proc_brk;
   logic               w_load;
   ps2_event_t         w_evt;
   ps2_event_t         w_held;

`ifdef PS2_SCAN_DECODER_CAPS_LOCK_EN
   logic               r_caps_lock;
   logic               r_caps_held;
   logic               w_caps_lock_nxt;
   logic               w_caps_held_nxt;
`endif

   assign w_timeout = (r_state != ST_IDLE) && (r_tmo_cnt == c_TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_skip_cnt <= '0;
         r_lshift   <= 1'b0;
         r_rshift   <= 1'b0;
`ifdef PS2_SCAN_DECODER_CAPS_LOCK_EN
         r_caps_lock <= 1'b0;
         r_caps_held <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_skip_cnt <= w_skip_nxt;
         r_lshift   <= w_lshift_nxt;
         r_rshift   <= w_rshift_nxt;
`ifdef PS2_SCAN_DECODER_CAPS_LOCK_EN
         r_caps_lock <= w_caps_lock_nxt;
         r_caps_held <= w_caps_held_nxt;
`endif
      end
   end

   // Idle timer: only advances while a prefix is pending and no byte arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (rx_valid || rx_error || (r_state == ST_IDLE) || w_timeout) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_skip_nxt  = r_skip_cnt;
      w_proc      = 1'b0;
      w_proc_ext  = 1'b0;
      w_proc_brk  = 1'b0;
      if (rx_error) begin
         w_state_nxt = ST_IDLE;
         w_skip_nxt  = '0;
      end else if (rx_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (rx_data == PS2_E0) begin
                  w_state_nxt = ST_E0;
               end else if (rx_data == PS2_F0) begin
                  w_state_nxt = ST_F0;
               end else if (rx_data == PS2_E1) begin
                  w_state_nxt = ST_SKIP;
                  w_skip_nxt  = PS2_E1_TAIL;
               end else if (!is_status_byte(rx_data)) begin
                  w_proc = 1'b1;
               end
            end
            ST_E0: begin
               if (rx_data == PS2_F0) begin
                  w_state_nxt = ST_E0F0;
               end else if (rx_data == PS2_E0) begin
                  w_state_nxt = ST_E0;
               end else if (rx_data == PS2_E1) begin
                  w_state_nxt = ST_SKIP;
                  w_skip_nxt  = PS2_E1_TAIL;
               end else begin
                  w_proc      = 1'b1;
                  w_proc_ext  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_F0: begin
               w_proc      = 1'b1;
               w_proc_brk  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            ST_E0F0: begin
               w_proc      = 1'b1;
               w_proc_ext  = 1'b1;
               w_proc_brk  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            ST_SKIP: begin
               if (r_skip_cnt <= 3'd1) begin
                  w_skip_nxt  = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_skip_nxt  = r_skip_cnt - 3'd1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_skip_nxt  = '0;
            end
         endcase
      end else if (w_timeout) begin
         w_state_nxt = ST_IDLE;
         w_skip_nxt  = '0;
      end
   end

   // Shift/caps bookkeeping and event qualification for a fully decoded code.
   always_comb begin
      w_lshift_nxt         = r_lshift;
      w_rshift_nxt         = r_rshift;
      w_load               = 1'b0;
      w_evt.scan_code      = rx_data;
      w_evt.extended       = w_proc_ext;
      w_evt.shift_mode     = r_lshift | r_rshift;
      w_evt.released       = w_proc_brk;
`ifdef PS2_SCAN_DECODER_CAPS_LOCK_EN
      w_caps_lock_nxt      = r_caps_lock;
      w_caps_held_nxt      = r_caps_held;
`endif
      if (w_proc) begin
         if (!w_proc_ext && (rx_data == PS2_LSHIFT)) begin
            w_lshift_nxt = !w_proc_brk;
         end else if (!w_proc_ext && (rx_data == PS2_RSHIFT)) begin
            w_rshift_nxt = !w_proc_brk;
         end else if (w_proc_ext && ((rx_data == PS2_LSHIFT) || (rx_data == PS2_RSHIFT))) begin
            // fake shifts surrounding extended keys carry no information
            w_load = 1'b0;
`ifdef PS2_SCAN_DECODER_CAPS_LOCK_EN
         end else if (!w_proc_ext && (rx_data == PS2_CAPS)) begin
            if (w_proc_brk) begin
               w_caps_held_nxt = 1'b0;
            end else begin
               if (!r_caps_held) begin
                  w_caps_lock_nxt = !r_caps_lock;
               end
               w_caps_held_nxt = 1'b1;
            end
`endif
         end else begin
            w_load = !w_proc_brk || EMIT_BREAK;
         end
      end
   end

   ps2_event_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .load_evt  (w_evt),
      .key_ready (key_ready),
      .key_valid (key_valid),
      .held_evt  (w_held),
      .overflow  (overflow)
   );

   assign scan_code  = w_held.scan_code;
   assign extended   = w_held.extended;
   assign shift_mode = w_held.shift_mode;
   assign released   = w_held.released;

`ifdef PS2_SCAN_DECODER_CAPS_LOCK_EN
   assign caps_lock = r_caps_lock;
`endif

endmodule

`default_nettype wire
